// File: rtl/modulator_pkg.sv
// Shared constants, types and lookup helpers for the symbol modulator.
// The carrier tables hold one 50 MHz cycle sampled at 500 MHz, scaled to 255.
package modulator_pkg;

  localparam int SAMPLES_PER_SYMBOL = 10;
  localparam int MIDSCALE           = 2048;
  localparam int CNT_W              = 4;

  typedef logic        [CNT_W-1:0] phase_t;
  typedef logic signed [8:0]       lut_t;
  typedef logic signed [2:0]       level_t;

  // Gray-coded amplitude: adjacent codes differ by one level step.
  function automatic level_t gray_level(input logic [1:0] code);
    level_t lvl;
    case (code)
      2'b00:   lvl = -3'sd3;
      2'b01:   lvl = -3'sd1;
      2'b11:   lvl = 3'sd1;
      2'b10:   lvl = 3'sd3;
      default: lvl = 3'sd0;
    endcase
    return lvl;
  endfunction

  function automatic lut_t cos_lut(input phase_t p);
    lut_t v;
    case (p)
      4'd0:    v = 9'sd255;
      4'd1:    v = 9'sd206;
      4'd2:    v = 9'sd79;
      4'd3:    v = -9'sd79;
      4'd4:    v = -9'sd206;
      4'd5:    v = -9'sd255;
      4'd6:    v = -9'sd206;
      4'd7:    v = -9'sd79;
      4'd8:    v = 9'sd79;
      4'd9:    v = 9'sd206;
      default: v = 9'sd0;
    endcase
    return v;
  endfunction

  function automatic lut_t sin_lut(input phase_t p);
    lut_t v;
    case (p)
      4'd0:    v = 9'sd0;
      4'd1:    v = 9'sd150;
      4'd2:    v = 9'sd243;
      4'd3:    v = 9'sd243;
      4'd4:    v = 9'sd150;
      4'd5:    v = 9'sd0;
      4'd6:    v = -9'sd150;
      4'd7:    v = -9'sd243;
      4'd8:    v = -9'sd243;
      4'd9:    v = -9'sd150;
      default: v = 9'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/modulator_carrier_lut.sv
// Combinational carrier table: phase index 0..9 to signed cos/sin samples.
module carrier_lut
  import modulator_pkg::*;
(
  input  phase_t phase_i,
  output lut_t   cos_o,
  output lut_t   sin_o
);

  // Pure table lookup; out-of-range phases read as zero.
  always_comb begin
    cos_o = cos_lut(phase_i);
    sin_o = sin_lut(phase_i);
  end

endmodule

// File: rtl/modulator.sv
// Symbol modulator: holds a 5-bit symbol for 10 clocks and emits
// 2048 + I*cos + Q*sin as a registered 12-bit offset-binary sample.
module modulator #(
  parameter int DIM0_WIDTH = 2,
  parameter int DIM1_WIDTH = 2,
  parameter int DIM2_WIDTH = 1,
  parameter int ADC_DEPTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIM0_WIDTH-1:0] x0,
  input  logic [DIM1_WIDTH-1:0] x1,
  input  logic [DIM2_WIDTH-1:0] x2,
  output logic [ADC_DEPTH-1:0]  out_sample
);
  import modulator_pkg::*;

  phase_t                cnt_q, cnt_d;
  logic [DIM0_WIDTH-1:0] sym_i_q, sym_i_d;
  logic [DIM1_WIDTH-1:0] sym_q_q, sym_q_d;
  logic [DIM2_WIDTH-1:0] sym_f_q, sym_f_d;
  logic [ADC_DEPTH-1:0]  out_q, out_d;

  logic                  load_s;
  logic [DIM0_WIDTH-1:0] cur_i_s;
  logic [DIM1_WIDTH-1:0] cur_q_s;
  logic [DIM2_WIDTH-1:0] cur_f_s;
  phase_t                phase_s;
  lut_t                  cos_s, sin_s;
  logic signed [13:0]    lvl_i_s, lvl_q_s, cos_ext_s, sin_ext_s;
  logic signed [13:0]    prod_i_s, prod_q_s, sum_s;

  // Symbol counter and input capture; the load edge uses the live inputs.
  always_comb begin
    load_s  = (cnt_q == 4'd0);
    cnt_d   = 4'd0;
    cur_i_s = sym_i_q;
    cur_q_s = sym_q_q;
    cur_f_s = sym_f_q;
    if (cnt_q == 4'(SAMPLES_PER_SYMBOL - 1)) begin
      cnt_d = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    if (load_s) begin
      cur_i_s = x0;
      cur_q_s = x1;
      cur_f_s = x2;
    end else begin
      cur_i_s = sym_i_q;
      cur_q_s = sym_q_q;
      cur_f_s = sym_f_q;
    end
    sym_i_d = cur_i_s;
    sym_q_d = cur_q_s;
    sym_f_d = cur_f_s;
  end

  // Phase index: the 100 MHz carrier steps through the table twice per symbol.
  always_comb begin
    phase_s = cnt_q;
    if (cur_f_s == 1'b0) begin
      phase_s = cnt_q;
    end else if (cnt_q < 4'd5) begin
      phase_s = cnt_q + cnt_q;
    end else begin
      phase_s = cnt_q + cnt_q - 4'd10;
    end
  end

  carrier_lut u_carrier_lut (
    .phase_i (phase_s),
    .cos_o   (cos_s),
    .sin_o   (sin_s)
  );

  // Multiply-add around mid-scale, clamped to the DAC code range.
  always_comb begin
    lvl_i_s   = 14'(gray_level(cur_i_s));
    lvl_q_s   = 14'(gray_level(cur_q_s));
    cos_ext_s = 14'(cos_s);
    sin_ext_s = 14'(sin_s);
    prod_i_s  = lvl_i_s * cos_ext_s;
    prod_q_s  = lvl_q_s * sin_ext_s;
    sum_s     = 14'sd2048 + prod_i_s + prod_q_s;
    out_d     = 12'd0;
    if (sum_s < 14'sd0) begin
      out_d = 12'd0;
    end else if (sum_s > 14'sd4095) begin
      out_d = 12'd4095;
    end else begin
      out_d = sum_s[11:0];
    end
  end

  // State and output registers with synchronous reset to mid-scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      sym_i_q <= '0;
      sym_q_q <= '0;
      sym_f_q <= '0;
      out_q   <= ADC_DEPTH'(MIDSCALE);
    end else begin
      cnt_q   <= cnt_d;
      sym_i_q <= sym_i_d;
      sym_q_q <= sym_q_d;
      sym_f_q <= sym_f_d;
      out_q   <= out_d;
    end
  end

  assign out_sample = out_q;

endmodule

// File: tb/tb_modulator.sv
// Directed bench for the modulator with hand-computed sample values.
module tb_modulator;

  logic        clk;
  logic        rst;
  logic [1:0]  x0;
  logic [1:0]  x1;
  logic [0:0]  x2;
  logic [11:0] out_sample;

  int checks_cnt;
  int errors_cnt;

  modulator dut (
    .clk        (clk),
    .rst        (rst),
    .x0         (x0),
    .x1         (x1),
    .x2         (x2),
    .out_sample (out_sample)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic check_value(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks_cnt++;
    if (observed !== expected) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_check(input string tag, input logic [11:0] expected);
    tick();
    check_value(tag, out_sample, expected);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst = 1'b1;
    x0  = 2'b10;
    x1  = 2'b11;
    x2  = 1'b0;

    for (int i = 0; i < 3; i++) tick_check("reset_hold", 12'd2048);

    // Symbol A: I=+3, Q=+1, 50 MHz; inputs switch to B before k=3.
    rst = 1'b0;
    tick_check("a_k0", 12'd2813);
    tick_check("a_k1", 12'd2816);
    tick_check("a_k2", 12'd2528);
    x0 = 2'b00;
    x1 = 2'b00;
    tick_check("a_k3_hold", 12'd2054);
    tick_check("a_k4_hold", 12'd1580);
    tick_check("a_k5_hold", 12'd1283);
    tick_check("a_k6_hold", 12'd1280);
    tick_check("a_k7_hold", 12'd1568);
    tick_check("a_k8_hold", 12'd2042);
    tick_check("a_k9_hold", 12'd2516);

    // Symbol B: I=-3, Q=-3 loads at edge 10.
    tick_check("b_k0", 12'd1283);
    tick_check("b_k1", 12'd980);
    tick_check("b_k2", 12'd1082);
    tick_check("b_k3", 12'd1556);
    for (int i = 4; i < 10; i++) tick();

    // Symbol A at 100 MHz, reset pulse at k=6.
    x0 = 2'b10;
    x1 = 2'b11;
    x2 = 1'b1;
    tick_check("f_k0", 12'd2813);
    tick_check("f_k1", 12'd2528);
    tick_check("f_k2", 12'd1580);
    tick_check("f_k3", 12'd1280);
    tick_check("f_k4", 12'd2042);
    tick_check("f_k5", 12'd2813);
    rst = 1'b1;
    x0  = 2'b01;
    x1  = 2'b10;
    x2  = 1'b0;
    tick_check("rst_mid", 12'd2048);

    // Symbol C: I=-1, Q=+3 loads on the first edge after release.
    rst = 1'b0;
    tick_check("c_k0", 12'd1793);
    tick_check("c_k1", 12'd2292);
    tick_check("c_k2", 12'd2698);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
